// File: rtl/avg_block_stream.sv
// Streaming block averager: sums groups of 2**LOG2_N samples at WIDTH+LOG2_N bits
// and emits the shifted (optionally rounded) mean over a valid/ready handshake.
module avg_block_stream #(
  parameter int WIDTH  = 4,
  parameter int LOG2_N = 1,
  parameter int ROUND  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = WIDTH + LOG2_N;
  localparam logic [AW-1:0]     RND  = (ROUND != 0) ? (AW'(1) << (LOG2_N - 1)) : '0;
  localparam logic [LOG2_N-1:0] LAST = '1;

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [AW-1:0]     sum;
  logic              accept;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_data  = res_q;

  // The closing sum folds in the last sample and the rounding bias at full width.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    accept  = in_valid && (state_q == ACCUM);
    sum     = acc_q + AW'(in_data) + RND;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == LAST) begin
            res_d   = WIDTH'(sum >> LOG2_N);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d = acc_q + AW'(in_data);
            cnt_d = cnt_q + LOG2_N'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_avg_block_stream.sv
// Bench for avg_block_stream: five parameterisations share one clock and reset,
// checked against a group-sum scoreboard driven by observed handshakes.
module tb_avg_block_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid  [5];
  logic       out_ready [5];
  logic [7:0] in_data   [5];
  logic       in_ready_w  [5];
  logic       out_valid_w [5];
  logic [3:0] od4 [3];
  logic [7:0] od8 [2];

  int compared;
  int mismatched;

  int gsum;
  int gcnt;
  int accepted;
  int results;
  int exp_q[$];
  bit hold_pending;
  int held_data;

  avg_block_stream #(.WIDTH(4), .LOG2_N(1), .ROUND(0)) u_w4_l1_r0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_data(in_data[0][3:0]), .out_valid(out_valid_w[0]), .out_ready(out_ready[0]),
    .out_data(od4[0]));
  avg_block_stream #(.WIDTH(4), .LOG2_N(1), .ROUND(1)) u_w4_l1_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_data(in_data[1][3:0]), .out_valid(out_valid_w[1]), .out_ready(out_ready[1]),
    .out_data(od4[1]));
  avg_block_stream #(.WIDTH(4), .LOG2_N(2), .ROUND(0)) u_w4_l2_r0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_data(in_data[2][3:0]), .out_valid(out_valid_w[2]), .out_ready(out_ready[2]),
    .out_data(od4[2]));
  avg_block_stream #(.WIDTH(8), .LOG2_N(3), .ROUND(0)) u_w8_l3_r0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready_w[3]),
    .in_data(in_data[3]), .out_valid(out_valid_w[3]), .out_ready(out_ready[3]),
    .out_data(od8[0]));
  avg_block_stream #(.WIDTH(8), .LOG2_N(3), .ROUND(1)) u_w8_l3_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[4]), .in_ready(in_ready_w[4]),
    .in_data(in_data[4]), .out_valid(out_valid_w[4]), .out_ready(out_ready[4]),
    .out_data(od8[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_log2(input int k);
    case (k)
      0, 1:    return 1;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit cfg_round(input int k);
    return (k == 1) || (k == 4);
  endfunction

  function automatic int get_od(input int k);
    if (k < 3) return int'(od4[k]);
    return int'(od8[k-3]);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    gsum = 0;
    gcnt = 0;
    accepted = 0;
    results = 0;
    exp_q.delete();
    hold_pending = 1'b0;
    held_data = 0;
  endtask

  // Reference: average of each completed group of N accepted samples, plain integer math.
  task automatic applyStimulus(input int k, input bit v, input int d, input bit r,
                               output bit ir, output bit ov, output int od);
    int n;
    @(negedge clk);
    ir = in_ready_w[k];
    ov = out_valid_w[k];
    od = get_od(k);
    checkOutput("ready_xor_valid", int'(ir ^ ov), 1);
    if (hold_pending) begin
      checkOutput("hold_valid", int'(ov), 1);
      checkOutput("hold_data", od, held_data);
    end
    in_valid[k]  = v;
    in_data[k]   = 8'(d);
    out_ready[k] = r;
    n = 1 << cfg_log2(k);
    if (v && ir) begin
      gsum += d;
      gcnt++;
      accepted++;
      if (gcnt == n) begin
        exp_q.push_back((gsum + (cfg_round(k) ? n / 2 : 0)) / n);
        gsum = 0;
        gcnt = 0;
      end
    end
    if (ov && r) begin
      results++;
      if (exp_q.size() == 0) checkOutput("unexpected_result", 1, 0);
      else checkOutput("result", od, exp_q.pop_front());
    end
    hold_pending = ov && !r;
    held_data = od;
  endtask

  task automatic applyGroup(input int k, input int n, input int a, input int b,
                            input int c, input int d, input int expv);
    int s[4];
    bit ir, ov;
    int od;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    for (int i = 0; i < n; i++) applyStimulus(k, 1'b1, s[i], 1'b1, ir, ov, od);
    applyStimulus(k, 1'b0, 0, 1'b1, ir, ov, od);
    checkOutput("latency_valid", int'(ov), 1);
    checkOutput("group_value", od, expv);
    applyStimulus(k, 1'b0, 0, 1'b1, ir, ov, od);
    checkOutput("valid_one_cycle", int'(ov), 0);
  endtask

  task automatic randomStream(input int k);
    bit ir, ov;
    int od;
    int cycles;
    modelReset();
    cycles = 0;
    while (accepted < 1000 && cycles < 20000) begin
      applyStimulus(k, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                    $urandom_range(0, 2) != 0, ir, ov, od);
      cycles++;
    end
    if (cycles >= 20000) checkOutput("stream_timeout", accepted, 1000);
    repeat (4) applyStimulus(k, 1'b0, 0, 1'b1, ir, ov, od);
    checkOutput("drain_empty", exp_q.size(), 0);
    checkOutput("result_count", results, 125);
  endtask

  initial begin
    bit ir, ov;
    int od;
    compared = 0;
    mismatched = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
      in_data[i] = 8'd0;
    end
    modelReset();
    rst_n = 1'b0;
    #1;
    checkOutput("reset_valid", int'(out_valid_w[0]), 0);
    checkOutput("reset_data", get_od(3), 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 1'b0, 0, 1'b1, ir, ov, od);
    checkOutput("ready_after_reset", int'(ir), 1);
    applyGroup(0, 2, 10, 7, 0, 0, 8);
    applyGroup(0, 2, 15, 15, 0, 0, 15);
    modelReset();
    applyGroup(1, 2, 10, 7, 0, 0, 9);
    applyGroup(1, 2, 15, 15, 0, 0, 15);
    modelReset();
    applyGroup(2, 4, 1, 2, 3, 4, 2);
    applyGroup(2, 4, 15, 15, 15, 15, 15);
    applyGroup(2, 4, 0, 0, 0, 3, 0);

    // Backpressure: result held for five stalled cycles while inputs are ignored.
    modelReset();
    applyStimulus(2, 1'b1, 1, 1'b0, ir, ov, od);
    applyStimulus(2, 1'b1, 2, 1'b0, ir, ov, od);
    applyStimulus(2, 1'b1, 3, 1'b0, ir, ov, od);
    applyStimulus(2, 1'b1, 4, 1'b0, ir, ov, od);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2, 1'b1, int'($urandom_range(0, 15)), 1'b0, ir, ov, od);
      checkOutput("bp_valid", int'(ov), 1);
      checkOutput("bp_data", od, 2);
      checkOutput("bp_ready", int'(ir), 0);
    end
    applyStimulus(2, 1'b0, 0, 1'b1, ir, ov, od);
    applyStimulus(2, 1'b0, 0, 1'b1, ir, ov, od);
    checkOutput("ready_after_release", int'(ir), 1);
    applyGroup(2, 4, 5, 6, 7, 8, 6);

    // Reset mid-group discards the partial sum.
    modelReset();
    applyStimulus(2, 1'b1, 15, 1'b1, ir, ov, od);
    applyStimulus(2, 1'b1, 15, 1'b1, ir, ov, od);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", int'(out_valid_w[2]), 0);
    checkOutput("midreset_data", get_od(2), 0);
    in_valid[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    applyStimulus(2, 1'b0, 0, 1'b1, ir, ov, od);
    checkOutput("ready_after_midreset", int'(ir), 1);
    applyGroup(2, 4, 4, 4, 4, 4, 4);

    randomStream(3);
    randomStream(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
